// File: rtl/spiker_adapter_pkg.sv
// Shared types and default sizing for the spiker adapter.
// Used by both the reader and the writer halves of the adapter.
package spiker_adapter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } spiker_writer_state_e;

   localparam int SPK_WIDTH     = 32;
   localparam int SPK_N_OUT_REG = 8;

endpackage

// File: rtl/spiker_writer.sv
// spiker_writer: captures the core output vector on a valid pulse
// and streams it word by word into the hw-writable result registers.
module spiker_writer
   import spiker_adapter_pkg::*;
#(
   parameter int WIDTH      = SPK_WIDTH,
   parameter int N_OUT_REG  = SPK_N_OUT_REG,
   parameter int DATA_WIDTH = N_OUT_REG * WIDTH,
   parameter int IDX_W      = (N_OUT_REG > 1) ? $clog2(N_OUT_REG) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  test_mode_i,
   input  logic [DATA_WIDTH-1:0] data_out_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic                  reg_we_o,
   output logic [IDX_W-1:0]      reg_idx_o,
   output logic [WIDTH-1:0]      reg_wdata_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  overrun_o,
   input  logic                  clr_i
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT_REG - 1);

   if (DATA_WIDTH != N_OUT_REG * WIDTH) begin : g_bad_width
      $error("spiker_writer: DATA_WIDTH must equal N_OUT_REG*WIDTH");
   end

   spiker_writer_state_e  r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_WIDTH-1:0] r_shadow;
   logic                  r_done;
   logic                  r_overrun;

   logic                  w_write;
   logic                  w_ready;
   logic                  w_accept;
   logic                  w_drop;
   logic                  w_last;
   logic                  w_unused_test_mode;
   logic [WIDTH-1:0]      w_words [N_OUT_REG];

   assign w_unused_test_mode = test_mode_i;

   assign w_write  = (r_state == WRITE);
   assign w_ready  = (r_state == IDLE) && !r_done;
   assign w_accept = valid_i && w_ready;
   assign w_drop   = valid_i && !w_ready;
   assign w_last   = w_write && (r_idx == LAST_IDX);

   for (genvar k = 0; k < N_OUT_REG; k++) begin : g_word
      assign w_words[k] = r_shadow[k*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_state <= WRITE;
         r_idx   <= '0;
      end else if (w_last) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else if (w_write) begin
         r_idx   <= r_idx + IDX_W'(1);
      end
   end

   // Shadow only loads on accept, so the core may change its output mid-transfer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_shadow <= '0;
      end else if (w_accept) begin
         r_shadow <= data_out_i;
      end
   end

   // Sticky flags: a set in the same cycle as clr_i takes priority.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_done    <= w_last | (r_done & ~clr_i);
         r_overrun <= w_drop | (r_overrun & ~clr_i);
      end
   end

   assign ready_o     = w_ready;
   assign reg_we_o    = w_write;
   assign busy_o      = w_write;
   assign reg_idx_o   = w_write ? r_idx : '0;
   assign reg_wdata_o = w_write ? w_words[r_idx] : '0;
   assign done_o      = r_done;
   assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_spiker_writer.sv
// Self-checking bench for spiker_writer: vector table, directed
// corner sequences and randomized traffic against a transfer-level model.
module tb_spiker_writer;
   import spiker_adapter_pkg::*;

   localparam int W  = SPK_WIDTH;
   localparam int N  = SPK_N_OUT_REG;
   localparam int DW = N * W;
   localparam int IW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst;
   logic          tm;
   logic [DW-1:0] data;
   logic          valid;
   logic          clr;
   logic          ready_o;
   logic          reg_we_o;
   logic [IW-1:0] reg_idx_o;
   logic [W-1:0]  reg_wdata_o;
   logic          busy_o;
   logic          done_o;
   logic          overrun_o;

   int errors = 0;
   int checks = 0;

   // transfer-level model: captured vector, words still to write, sticky flags
   logic [W-1:0] m_vec [N];
   int           m_rem;
   int           m_pos;
   bit           m_done;
   bit           m_ovr;

   typedef struct {
      bit          v;
      bit          c;
      logic [31:0] base;
      bit          we;
      logic [2:0]  idx;
      logic [31:0] wd;
      bit          done;
      bit          ovr;
      bit          rdy;
   } vec_t;

   vec_t tbl [$];

   always #5 clk = ~clk;

   spiker_writer dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .test_mode_i (tm),
      .data_out_i  (data),
      .valid_i     (valid),
      .ready_o     (ready_o),
      .reg_we_o    (reg_we_o),
      .reg_idx_o   (reg_idx_o),
      .reg_wdata_o (reg_wdata_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .overrun_o   (overrun_o),
      .clr_i       (clr)
   );

   function automatic logic [DW-1:0] mkvec(input logic [31:0] base);
      logic [DW-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = base + 32'(k);
      return v;
   endfunction

   function automatic logic [DW-1:0] rndvec();
      logic [DW-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = $urandom;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_rem  = 0;
      m_pos  = 0;
      m_done = 0;
      m_ovr  = 0;
      for (int k = 0; k < N; k++) m_vec[k] = '0;
   endtask

   task automatic model_step(input bit v, input bit c, input logic [DW-1:0] d);
      bit rdy;
      bit last;
      rdy    = (m_rem == 0) && !m_done;
      last   = (m_rem == 1);
      m_ovr  = (v && !rdy) || (m_ovr && !c);
      m_done = last || (m_done && !c);
      if (v && rdy) begin
         for (int k = 0; k < N; k++) m_vec[k] = d[k*W +: W];
         m_pos = 0;
         m_rem = N;
      end else if (m_rem > 0) begin
         m_rem--;
         m_pos = (m_rem > 0) ? m_pos + 1 : 0;
      end
   endtask

   task automatic compare_all(input string name);
      logic [63:0] a;
      logic [63:0] e;
      bit          we;
      we = (m_rem > 0);
      a  = {24'b0, reg_we_o, reg_idx_o, reg_wdata_o,
            done_o, overrun_o, ready_o, busy_o};
      e  = {24'b0, we, we ? IW'(m_pos) : IW'(0), we ? m_vec[m_pos] : 32'h0,
            m_done, m_ovr, (m_rem == 0) && !m_done, we};
      check(name, a, e);
   endtask

   task automatic step(input bit v, input bit c, input logic [DW-1:0] d,
                       input string name);
      valid = v;
      clr   = c;
      data  = d;
      @(posedge clk);
      #1;
      if (!rst) model_step(v, c, d);
      compare_all(name);
   endtask

   function automatic vec_t mk(input bit v, input bit c, input logic [31:0] base,
                               input bit we, input logic [2:0] idx,
                               input logic [31:0] wd, input bit dn,
                               input bit ov, input bit rdy);
      vec_t r;
      r.v = v; r.c = c; r.base = base; r.we = we; r.idx = idx;
      r.wd = wd; r.done = dn; r.ovr = ov; r.rdy = rdy;
      return r;
   endfunction

   initial begin
      logic [DW-1:0] vsave;

      // basic transfer with a dropped vector at cycle 3, clr, second transfer
      tbl.push_back(mk(1, 0, 32'hA000_0000, 1, 0, 32'hA000_0000, 0, 0, 0));
      for (int r = 1; r < 8; r++)
         tbl.push_back(mk(r == 3, 0, (r == 3) ? 32'hB000_0000 : 32'hA000_0000,
                          1, 3'(r), 32'hA000_0000 + 32'(r), 0, r >= 3, 0));
      tbl.push_back(mk(0, 0, 32'hA000_0000, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 32'hC000_0000, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 1, 32'hC000_0000, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 32'hC000_0000, 1, 0, 32'hC000_0000, 0, 0, 0));
      for (int r = 12; r < 19; r++)
         tbl.push_back(mk(0, 0, 32'hD000_0000, 1, 3'(r - 11),
                          32'hC000_0000 + 32'(r - 11), 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'hD000_0000, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 32'hD000_0000, 0, 0, 0, 0, 0, 1));

      rst   = 1'b1;
      tm    = 1'b0;
      valid = 1'b0;
      clr   = 1'b0;
      data  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step(0, 0, '0, "idle");

      foreach (tbl[i]) begin
         valid = tbl[i].v;
         clr   = tbl[i].c;
         data  = mkvec(tbl[i].base);
         @(posedge clk);
         #1;
         model_step(tbl[i].v, tbl[i].c, data);
         check($sformatf("tbl[%0d]", i),
               {24'b0, reg_we_o, reg_idx_o, reg_wdata_o, done_o, overrun_o, ready_o},
               {25'b0, tbl[i].we, tbl[i].idx, tbl[i].wd,
                tbl[i].done, tbl[i].ovr, tbl[i].rdy});
      end

      // overrun set-wins, clr during WRITE, done set-wins
      step(1, 0, mkvec(32'h1111_0000), "sw_accept");
      step(1, 0, rndvec(), "sw_drop");
      step(1, 1, rndvec(), "sw_ovr_setclr");
      check("overrun_set_wins", 64'(overrun_o), 64'd1);
      step(0, 1, rndvec(), "sw_clr_in_write");
      check("clr_in_write_busy", 64'(busy_o), 64'd1);
      for (int i = 0; i < 4; i++) step(0, 0, '0, "sw_write");
      check("sw_last_idx", 64'(reg_idx_o), 64'(N - 1));
      step(0, 1, '0, "sw_done_setclr");
      check("done_set_wins", 64'(done_o), 64'd1);
      step(0, 1, '0, "sw_clear");

      // reset in cycle 4 of a transfer
      step(1, 0, mkvec(32'h2222_0000), "rst_accept");
      for (int i = 0; i < 3; i++) step(0, 0, '0, "rst_write");
      rst = 1'b1;
      #1;
      model_reset();
      compare_all("rst_mid_write");
      check("rst_no_strobe", 64'(reg_we_o), 64'd0);
      step(0, 0, '0, "rst_hold");
      step(1, 0, rndvec(), "rst_hold_valid");
      rst = 1'b0;
      check("rst_ready", 64'(ready_o), 64'd1);
      step(1, 0, mkvec(32'h3333_0000), "post_rst_accept");
      for (int i = 0; i < N; i++) step(0, 0, '0, "post_rst_write");
      check("post_rst_done", 64'(done_o), 64'd1);
      step(0, 1, '0, "post_rst_clr");

      // core output changes every cycle while writing
      vsave = rndvec();
      step(1, 0, vsave, "stab_accept");
      for (int i = 0; i < N; i++) begin
         check($sformatf("stab_word%0d", i), 64'(reg_wdata_o),
               64'(vsave[i*W +: W]));
         step(0, 0, rndvec(), "stab_write");
      end
      step(0, 1, rndvec(), "stab_clr");

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
              rndvec(), "rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
